// File: rtl/binop_sweep_checker.sv
// binop_sweep_checker: exhaustive stimulus generator and in-order response checker for a binary-operator DUT.
// Ports:
//   clk, rst_n                  rising-edge clock, asynchronous active-low reset
//   start, signed_mode          begin a sweep when idle; signed_mode is latched with start
//   op_valid/op_ready           stimulus handshake carrying op_src1/op_src2
//   rsp_valid/rsp_word/rsp_flag in-order DUT responses: 10 SIZE-bit words and 10 flags
//   busy, done, pass            sweep status; done pulses once, pass is held until the next start
//   err_count                   saturating count of mismatching vectors
//   fail_valid/fail_src1/2      operands of the first mismatching vector
//   proto_err                   sticky: a response arrived with nothing outstanding
module binop_sweep_checker #(
    parameter int SIZE    = 4,
    parameter int MAX_OUT = 4,
    parameter int ERRW    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    output logic               op_valid,
    input  logic               op_ready,
    output logic [SIZE-1:0]    op_src1,
    output logic [SIZE-1:0]    op_src2,
    input  logic               rsp_valid,
    input  logic [10*SIZE-1:0] rsp_word,
    input  logic [9:0]         rsp_flag,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERRW-1:0]    err_count,
    output logic               fail_valid,
    output logic [SIZE-1:0]    fail_src1,
    output logic [SIZE-1:0]    fail_src2,
    output logic               proto_err
);
    localparam int AW = $clog2(MAX_OUT);
    localparam int OW = AW + 1;
    localparam int CW = 2 * SIZE;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    fifo_q [MAX_OUT];
    logic             sgn_q, sgn_d;
    logic [ERRW-1:0]  err_q, err_d;
    logic             fv_q, fv_d;
    logic [SIZE-1:0]  fs1_q, fs1_d, fs2_q, fs2_d;
    logic             proto_q, proto_d;
    logic             pass_q, pass_d;

    logic             clr, issue, pop, orphan, last, hit;
    logic [SIZE-1:0]  a, b;
    logic [9:0][SIZE-1:0] exp_w;
    logic [9:0]       exp_f;
    logic             lt, eq;

    // The counter holds {src1, src2}, so src2 is naturally the inner loop.
    assign op_src1  = cnt_q[CW-1:SIZE];
    assign op_src2  = cnt_q[SIZE-1:0];
    assign op_valid = (state_q == S_ISSUE) && (occ_q != OW'(MAX_OUT));
    assign busy     = state_q != S_IDLE;
    assign done     = state_q == S_DONE;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign fail_src1  = fs1_q;
    assign fail_src2  = fs2_q;
    assign proto_err  = proto_q;

    assign clr    = (state_q == S_IDLE) && start;
    assign issue  = op_valid && op_ready;
    assign pop    = rsp_valid && (occ_q != '0);
    // A response with an empty FIFO is flagged and dropped without popping.
    assign orphan = rsp_valid && (occ_q == '0);
    assign last   = cnt_q == '1;
    assign {a, b} = fifo_q[rptr_q];

    // Expected results for the vector at the FIFO head; shifts by SIZE or more yield 0.
    always_comb begin
        exp_w[0] = a + b;
        exp_w[1] = a - b;
        exp_w[2] = a << b;
        exp_w[3] = a >> b;
        exp_w[4] = a * b;
        exp_w[5] = a & b;
        exp_w[6] = a ^ b;
        exp_w[7] = ~(a ^ b);
        exp_w[8] = ~(a ^ b);
        exp_w[9] = a | b;
        lt = sgn_q ? ($signed(a) < $signed(b)) : (a < b);
        eq = a == b;
        exp_f = {!eq, eq, (a != '0) || (b != '0), (a != '0) && (b != '0), !eq, eq, !lt, !(lt || eq), lt || eq, lt};
    end

    assign hit = pop && ((exp_w != rsp_word) || (exp_f != rsp_flag));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = start ? S_ISSUE : S_IDLE;
            S_ISSUE: state_d = (issue && last) ? S_DRAIN : S_ISSUE;
            S_DRAIN: state_d = (occ_q == '0) ? S_DONE : S_DRAIN;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = clr ? '0 : issue ? cnt_q + CW'(1) : cnt_q;
        occ_d   = occ_q + OW'(issue) - OW'(pop);
        sgn_d   = clr ? signed_mode : sgn_q;
        err_d   = clr ? '0 : (hit && (err_q != '1)) ? err_q + ERRW'(1) : err_q;
        fv_d    = !clr && (fv_q || hit);
        fs1_d   = clr ? '0 : (hit && !fv_q) ? a : fs1_q;
        fs2_d   = clr ? '0 : (hit && !fv_q) ? b : fs2_q;
        proto_d = orphan || (!clr && proto_q);
        // The last compare lands in err_q before DRAIN can see an empty FIFO, so DONE sees the final count.
        pass_d  = clr ? 1'b0 : (state_q == S_DONE) ? ((err_q == '0) && !proto_q) : pass_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            occ_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            sgn_q   <= 1'b0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fs1_q   <= '0;
            fs2_q   <= '0;
            proto_q <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            occ_q   <= occ_d;
            wptr_q  <= issue ? wptr_q + AW'(1) : wptr_q;
            rptr_q  <= pop ? rptr_q + AW'(1) : rptr_q;
            sgn_q   <= sgn_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fs1_q   <= fs1_d;
            fs2_q   <= fs2_d;
            proto_q <= proto_d;
            pass_q  <= pass_d;
        end
    end

    // Operand storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (issue) fifo_q[wptr_q] <= {op_src1, op_src2};
    end
endmodule

// File: doc/binop_sweep_checker.md
Name: binop_sweep_checker

Overview:
- Sequential stimulus generator and response checker for a binary-operator DUT: the opposite end of a same-size operator test block.
- Sweeps every (src1, src2) pair of SIZE bits and issues the pairs over a valid/ready channel.
- Accepts in-order DUT responses (10 SIZE-bit words, 10 flags) and compares each against an internally computed expected value.
- Used in system tests to run exhaustive checks of operator translations at any latency.

Parameters:
- SIZE, 4: operand width, 1..8.
- MAX_OUT, 4: maximum outstanding vectors, power of two, 2..16.
- ERRW, 16: width of the error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins a sweep when idle; ignored while busy.
- signed_mode  in  1  sampled with start; selects signed comparisons.
- op_valid  out  1  stimulus valid.
- op_ready  in  1  DUT accepts stimulus.
- op_src1  out  SIZE  operand 1.
- op_src2  out  SIZE  operand 2.
- rsp_valid  in  1  DUT response valid, in issue order.
- rsp_word  in  10*SIZE  result words; slice k is bits [k*SIZE +: SIZE].
- rsp_flag  in  10  1-bit results.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when the sweep completes.
- pass  out  1  held after done: err_count==0 and proto_err==0.
- err_count  out  ERRW  mismatching vectors, saturating.
- fail_valid  out  1  a first failure has been captured.
- fail_src1  out  SIZE  operand 1 of the first failing vector.
- fail_src2  out  SIZE  operand 2 of the first failing vector.
- proto_err  out  1  sticky: response arrived with nothing outstanding.

Behaviour:
- Reset (async, rst_n low): all outputs are 0; FSM goes to IDLE; FIFO and counters clear. Reset mid-sweep aborts the sweep and does not pulse done.
- FSM states:
  - IDLE: on start, go to ISSUE and clear err_count, fail_*, proto_err and pass. Latch signed_mode.
  - ISSUE: op_valid=1 whenever outstanding<MAX_OUT. A handshake completes when op_valid&&op_ready. After the final pair (src1=src2=all ones) is accepted, go to DRAIN.
  - DRAIN: wait until outstanding==0, then go to DONE.
  - DONE: one cycle; done=1; pass is registered; go to IDLE.
- busy=1 in ISSUE, DRAIN and DONE.
- Sweep order: src2 is the inner loop, src1 the outer; both start at 0. Total vectors: 2^(2*SIZE).
- op_src1/op_src2 stay stable while op_valid && !op_ready.
- Each accepted pair is pushed into an operand FIFO of depth MAX_OUT.
- Each rsp_valid pops the FIFO and is compared in the same cycle; comparison results are registered.
- Simultaneous issue and response in one cycle leaves the outstanding count unchanged. Responses are accepted in any state.
- rsp_valid with an empty FIFO sets proto_err; the response is discarded and no pop occurs.
- Expected words, index 0..9: plus, minus, shl, shr, mult, and, xor, xnor, xnor, or.
  - All are truncated to SIZE bits.
  - Shift amount is src2 treated as unsigned; an amount of SIZE or more gives 0.
  - Word results do not depend on signed_mode.
- Expected flags, index 0..9: lt, lte, gt, gte, eq, neq, logand, logor, ceq, cne.
  - lt/lte/gt/gte use two's-complement comparison when signed_mode=1, unsigned otherwise.
  - logand/logor reduce each operand to nonzero.
  - ceq=eq and cne=neq (no X/Z in this block).
- Mismatch means any word or flag differs.
  - On mismatch, err_count increments, saturating at all ones.
  - On the first mismatch only, capture fail_src1/fail_src2 and set fail_valid.
- pass = (err_count==0)&&!proto_err, registered in DONE and held until the next start.
- A mismatch on the last response is counted before done pulses: done occurs at least 1 cycle after the final compare.

Test Plan:
- SIZE=2, MAX_OUT=4, zero-latency correct model, op_ready=1 → 16 handshakes in order (0,0),(0,1)…(3,3); done pulses once; pass=1; err_count=0.
- SIZE=3, signed_mode=1, correct signed model → src1=3'b111 vs src2=3'b001 expects lt=1; pass=1.
- Same, but the model uses unsigned lt → err_count = number of sign-differing pairs where lt disagrees; fail_src1/fail_src2 equal the first such pair in sweep order.
- SIZE=2, op_ready toggling every cycle, model latency 3, MAX_OUT=2 → outstanding never exceeds 2; operands stable while stalled; pass=1.
- Idle with rsp_valid pulsed once → proto_err=1 and stays set; next sweep clears it at start.
- SIZE=4 with rst_n low mid-ISSUE → all outputs 0 immediately; no done pulse; a new start sweeps from (0,0).
